comparator_sweeper: RTL and testbench
=====================================

# comparator_sweeper

Sequential exhaustive driver and checker for the 4-bit magnitude comparator (`a0..a3`, `b0..b3` → `a_bigger`, `b_bigger`, `equals`).

- On `start`, it walks all 256 operand pairs and drives each pair onto the comparator's inputs.
- After a programmable settle time, it samples the comparator's three flags and checks them against an internal golden compare.
- It reports the error count, the first failing pair, and an overall pass/fail.
- It sits at the opposite end of the comparator interface from the comparator itself, as an on-chip self-test alongside it.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 1: cycles operands are held before the flags are sampled. Legal range 1..15.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a sweep. Accepted only in IDLE.
- `abort`, in, 1: cancel a sweep in progress.
- `a0`, `a1`, `a2`, `a3`, out, 1 each: operand A to the comparator. `a3` is the MSB.
- `b0`, `b1`, `b2`, `b3`, out, 1 each: operand B to the comparator. `b3` is the MSB.
- `a_bigger`, `b_bigger`, `equals`, in, 1 each: flags returned by the comparator.
- `busy`, out, 1: high while a sweep is running.
- `done`, out, 1: one-cycle pulse when a sweep completes.
- `pass`, out, 1: high when the last completed sweep had zero errors.
- `err_count`, out, 9: number of mismatching pairs, 0..256.
- `first_err_a`, `first_err_b`, out, 4 each: operands of the first mismatching pair.

## Operation

- The 8-bit pair index `idx` maps as follows: `idx[7:4]` = A, `idx[3:0]` = B. The sweep order is `idx` 0..255.
- Golden result uses unsigned compare:
  - A > B gives flags 100 (`a_bigger`, `b_bigger`, `equals`).
  - A < B gives 010.
  - A == B gives 001.
- A mismatch is any difference in the 3-bit flag vector. Illegal combinations (000, 011, 111, …) are always mismatches.

State machine:
- **IDLE**
  - Operand outputs are 0 and `busy` = 0.
  - When `start` = 1: clear `err_count`, `first_err_a`, `first_err_b` and `pass`; set `idx` = 0; load the settle counter with `SETTLE_CYCLES`; go to SETTLE.
- **SETTLE**
  - Operands = `idx`.
  - The settle counter decrements each cycle. On the cycle it reads 1, go to CHECK.
- **CHECK**, one cycle:
  - Compare the flags against the golden result.
  - On a mismatch, increment `err_count`. If `err_count` was 0, also latch A/B into `first_err_a`/`first_err_b`.
  - If `idx` = 255, go to DONE. Otherwise increment `idx`, reload the settle counter, and go to SETTLE.
- **DONE**, one cycle:
  - `done` = 1.
  - `pass` <= (final `err_count` == 0), including a mismatch detected in the last CHECK.
  - Go to IDLE.

Rules:
- `err_count` cannot overflow (maximum 256). No saturation logic is required.
- `start` in SETTLE, CHECK or DONE is ignored; no queuing.
- `abort` = 1 in SETTLE or CHECK:
  - Go to IDLE next cycle with no `done` pulse and `pass` = 0.
  - `err_count` and `first_err_*` keep their values.
  - A CHECK cycle coincident with `abort` still counts its mismatch.
- `abort` in IDLE or DONE has no effect. `abort` and `start` together in IDLE: `start` wins.
- `pass`, `err_count` and `first_err_*` hold their values in IDLE until the next accepted `start`.

## Timing

- Reset (asynchronous, `rst_n` low) clears immediately:
  - State to IDLE.
  - All operand outputs, `busy`, `done` and `pass` to 0.
  - `err_count` and `first_err_*` to 0.
  - `idx` and the settle counter to 0.
- Reset mid-sweep aborts with no `done` pulse. Release is synchronous to the next `clk` edge.
- The `start` edge enters SETTLE, so `busy` = 1 and operands = pair 0 in the following cycle.
- Each pair occupies `SETTLE_CYCLES` + 1 cycles. The flags are sampled at the end of the CHECK cycle.
- Total from the accepting edge to `done` high: 256 × (`SETTLE_CYCLES` + 1) + 1 cycles.
  - For `SETTLE_CYCLES` = 1, this is 513.
- `busy` drops in the same cycle `done` rises. A new `start` is accepted at the earliest one cycle after `done`.
- All outputs are registered. The only combinational input dependency is the sampling inside CHECK.

## Test plan

1. **Correct comparator model, `SETTLE_CYCLES` = 1.** Pulse `start` → `done` 513 cycles later, `err_count` = 0, `pass` = 1, `first_err` = 0/0.
2. **`equals` stuck at 0.** → `err_count` = 16, `pass` = 0, `first_err_a` = 0, `first_err_b` = 0.
3. **`a_bigger` and `b_bigger` swapped.** → `err_count` = 240, `first_err_a` = 0, `first_err_b` = 1.
4. **Correct model, `SETTLE_CYCLES` = 3.** → `done` after 1025 cycles, `pass` = 1. A second `start` at cycle 100 is ignored and the run completes unchanged.
5. **`abort` while A = 9, B = 4, with `equals` stuck at 0.** → IDLE next cycle, no `done`, `pass` = 0, `err_count` = 9.
6. **`rst_n` low mid-sweep (async, between clock edges).** → All outputs 0 immediately. After release, a new `start` completes with `pass` = 1.

Source files
------------

// File: rtl/comparator_sweeper.sv
// comparator_sweeper: on-chip exhaustive sweep of a 4-bit magnitude comparator, checking all 256 operand pairs
// against a golden compare and reporting error count, first failing pair and pass/fail.
module comparator_sweeper #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       b0,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  input  logic       a_bigger,
  input  logic       b_bigger,
  input  logic       equals,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [3:0] first_err_a,
  output logic [3:0] first_err_b
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t     state;
  logic [7:0] idx;
  logic [3:0] cnt;
  logic [2:0] golden;
  logic       mismatch;
  always_comb begin
    golden   = idx[7:4] > idx[3:0] ? 3'b100 : idx[7:4] < idx[3:0] ? 3'b010 : 3'b001;
    mismatch = {a_bigger, b_bigger, equals} != golden;
  end
  // idx doubles as the operand register; it is held at 0 whenever no sweep is running
  assign {a3, a2, a1, a0} = idx[7:4];
  assign {b3, b2, b1, b0} = idx[3:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= SETTLE;
          busy        <= 1'b1;
          pass        <= 1'b0;
          err_count   <= '0;
          first_err_a <= '0;
          first_err_b <= '0;
          idx         <= '0;
          cnt         <= 4'(SETTLE_CYCLES);
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end else if (cnt == 4'd1) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 9'd1;
            if (err_count == 9'd0) begin
              first_err_a <= idx[7:4];
              first_err_b <= idx[3:0];
            end
          end
          idx <= abort ? 8'd0 : idx + 8'd1;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (idx == 8'd255) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= err_count == 9'd0 && !mismatch;
          end else begin
            state <= SETTLE;
            cnt   <= 4'(SETTLE_CYCLES);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_comparator_sweeper.sv
// tb_comparator_sweeper: two sweepers (settle 1 and 3) against a faultable comparator model; a cycle-level
// reference model of the sweep is compared every cycle, plus literal end-of-test expectations.
module tb_comparator_sweeper;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] start = 2'b00;
  int         mode = 0;
  logic [3:0] opa [2];
  logic [3:0] opb [2];
  logic [2:0] fl [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic       pass_v [2];
  logic [8:0] errc [2];
  logic [3:0] fa [2];
  logic [3:0] fb [2];
  int sc [2] = '{1, 3};
  int t [2], xerr [2], xfa [2], xfb [2], xpass [2];
  int checks = 0, errors = 0, cyc;

  always #5 clk = ~clk;

  // mode 0: correct comparator, 1: equals stuck at 0, 2: a_bigger/b_bigger swapped
  function automatic logic [2:0] flags(int m, logic [3:0] a, logic [3:0] b);
    logic [2:0] g;
    g = a > b ? 3'b100 : a < b ? 3'b010 : 3'b001;
    return m == 1 ? {g[2:1], 1'b0} : m == 2 ? {g[1], g[2], g[0]} : g;
  endfunction

  function automatic bit faulty(int m, int p);
    return m == 1 ? (p >> 4) == (p & 15) : m == 2 ? (p >> 4) != (p & 15) : 1'b0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    assign fl[g] = flags(mode, opa[g], opb[g]);
    comparator_sweeper #(.SETTLE_CYCLES(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort),
      .a0(opa[g][0]), .a1(opa[g][1]), .a2(opa[g][2]), .a3(opa[g][3]),
      .b0(opb[g][0]), .b1(opb[g][1]), .b2(opb[g][2]), .b3(opb[g][3]),
      .a_bigger(fl[g][2]), .b_bigger(fl[g][1]), .equals(fl[g][0]),
      .busy(busy_v[g]), .done(done_v[g]), .pass(pass_v[g]),
      .err_count(errc[g]), .first_err_a(fa[g]), .first_err_b(fb[g])
    );
  end

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      t[k] = 0; xerr[k] = 0; xfa[k] = 0; xfb[k] = 0; xpass[k] = 0;
    end
  endtask

  // t = cycles since the accepting edge (0 = idle); pair p is checked in cycle (p+1)*(S+1)
  task automatic step;
    int n, p;
    if (!rst_n) model_reset();
    else for (int k = 0; k < 2; k++) begin
      n = 256 * (sc[k] + 1);
      if (t[k] >= 1 && t[k] <= n && t[k] % (sc[k] + 1) == 0) begin
        p = t[k] / (sc[k] + 1) - 1;
        if (faulty(mode, p)) begin
          if (xerr[k] == 0) begin xfa[k] = p >> 4; xfb[k] = p & 15; end
          xerr[k]++;
        end
      end
      if (t[k] >= 1 && t[k] <= n && abort) t[k] = 0;
      else if (t[k] == n) begin t[k] = n + 1; xpass[k] = int'(xerr[k] == 0); end
      else if (t[k] == n + 1) t[k] = 0;
      else if (t[k] >= 1) t[k]++;
      else if (start[k]) begin
        t[k] = 1; xerr[k] = 0; xfa[k] = 0; xfb[k] = 0; xpass[k] = 0;
      end
    end
  endtask

  task automatic compare;
    int n, p;
    bit act;
    for (int k = 0; k < 2; k++) begin
      n = 256 * (sc[k] + 1);
      act = t[k] >= 1 && t[k] <= n;
      p = act ? (t[k] - 1) / (sc[k] + 1) : 0;
      chk("busy", k, busy_v[k], act);
      chk("done", k, done_v[k], int'(t[k] == n + 1));
      chk("operands", k, {opa[k], opb[k]}, p);
      chk("err_count", k, errc[k], xerr[k]);
      chk("first_err_a", k, fa[k], xfa[k]);
      chk("first_err_b", k, fb[k], xfb[k]);
      chk("pass", k, pass_v[k], xpass[k]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    step();
    @(negedge clk);
    compare();
  endtask

  task automatic go(input int k, input int m);
    mode = m;
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int lim, inout int c);
    while (!done_v[k] && c < lim) begin
      tick();
      c++;
    end
    if (!done_v[k]) chk("done_timeout", k, 0, 1);
  endtask

  task automatic sweep_result(input int k, input int m, input int lat, input int e, input int a, input int b);
    go(k, m);
    cyc = 1;
    wait_done(k, lat + 50, cyc);
    chk("latency", k, cyc, lat);
    tick();
    chk("final_err", k, errc[k], e);
    chk("final_pass", k, pass_v[k], int'(e == 0));
    chk("final_fa", k, fa[k], a);
    chk("final_fb", k, fb[k], b);
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    chk("reset_busy", 0, busy_v[0], 0);
    chk("reset_err", 1, errc[1], 0);
    rst_n = 1'b1;
    tick();
    sweep_result(0, 0, 513, 0, 0, 0);
    sweep_result(0, 1, 513, 16, 0, 0);
    sweep_result(0, 2, 513, 240, 0, 1);
    go(1, 0);
    cyc = 1;
    repeat (98) begin tick(); cyc++; end
    start[1] = 1'b1;
    tick();
    cyc++;
    start[1] = 1'b0;
    wait_done(1, 1100, cyc);
    chk("latency_s3", 1, cyc, 1025);
    tick();
    chk("final_pass_s3", 1, pass_v[1], 1);
    go(0, 1);
    repeat (296) tick();
    chk("abort_opa", 0, opa[0], 9);
    chk("abort_opb", 0, opb[0], 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 0, busy_v[0], 0);
    chk("abort_done", 0, done_v[0], 0);
    chk("abort_err", 0, errc[0], 9);
    chk("abort_pass", 0, pass_v[0], 0);
    repeat (3) tick();
    go(0, 1);
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 0, busy_v[0], 0);
    chk("async_ops", 0, {opa[0], opb[0]}, 0);
    chk("async_err", 0, errc[0], 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    sweep_result(0, 0, 513, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
